// File: rtl/rate_divider_bank.sv
// rate_divider_bank: bank of programmable tick dividers, each periodic or one-shot.
// Optional RATE_DIV_SYNC_EN adds a sync_all input that phase-aligns every channel.
module rate_divider_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH = 26,
    parameter int DEFAULT_DIV = 49999999,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_div,
    input  logic                wr_oneshot,
    input  logic [CHANNELS-1:0] ch_en,
`ifdef RATE_DIV_SYNC_EN
    input  logic                sync_all,
`endif
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] d, q;
        logic m, t, wr;
        state_t st;
        // channel indices beyond CHANNELS never match, so such writes are dropped
        assign wr = wr_en && wr_chan == CW'(i);
        assign tick[i] = t;
        assign busy[i] = st == RUN;
        always_ff @(posedge clock or negedge resetn)
            if (!resetn) begin
                d <= DEF;
                q <= DEF;
                m <= 1'b0;
                t <= 1'b0;
                st <= IDLE;
            end else if (wr) begin
                d <= wr_div;
                q <= wr_div;
                m <= wr_oneshot;
                t <= 1'b0;
                st <= ch_en[i] ? RUN : IDLE;
            end
`ifdef RATE_DIV_SYNC_EN
            else if (sync_all) begin
                q <= d;
                t <= 1'b0;
                st <= ch_en[i] ? RUN : IDLE;
            end
`endif
            else if (!ch_en[i]) begin
                q <= d;
                t <= 1'b0;
                st <= IDLE;
            end else if (st == DONE) begin
                t <= 1'b0;
            end else if (q != '0) begin
                q <= q - 1'b1;
                t <= 1'b0;
                st <= RUN;
            end else begin
                q <= m ? '0 : d;
                t <= 1'b1;
                st <= m ? DONE : RUN;
            end
    end
endmodule

// File: tb/tb_rate_divider_bank.sv
// tb_rate_divider_bank: directed scoreboard bench for rate_divider_bank (CHANNELS=4, WIDTH=8, DEFAULT_DIV=9).
// A CHANNELS=3 instance exercises writes to a nonexistent channel.
module tb_rate_divider_bank;
    logic clock = 1'b0, resetn, wr_en, wr_en3, wr_oneshot;
    logic [1:0] wr_chan;
    logic [7:0] wr_div;
    logic [3:0] ch_en, tick, busy;
    logic [2:0] ch_en3, tick3, busy3;
`ifdef RATE_DIV_SYNC_EN
    logic sync_all;
`endif
    int errors = 0, checks = 0;
    typedef struct {string tag; logic [3:0] t; logic [3:0] b;} exp_t;
    exp_t sb[$];

    rate_divider_bank #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(9)) u_dut (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_chan(wr_chan), .wr_div(wr_div),
        .wr_oneshot(wr_oneshot), .ch_en(ch_en),
`ifdef RATE_DIV_SYNC_EN
        .sync_all(sync_all),
`endif
        .tick(tick), .busy(busy));

    rate_divider_bank #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(9)) u_dut3 (
        .clock(clock), .resetn(resetn), .wr_en(wr_en3), .wr_chan(wr_chan), .wr_div(wr_div),
        .wr_oneshot(wr_oneshot), .ch_en(ch_en3),
`ifdef RATE_DIV_SYNC_EN
        .sync_all(1'b0),
`endif
        .tick(tick3), .busy(busy3));

    always #5 clock = ~clock;

    task automatic cyc(input string tag, input logic [3:0] et, input logic [3:0] eb);
        exp_t e;
        sb.push_back('{tag, et, eb});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        assert (tick === e.t) else begin errors++; $error("FAIL %s tick: observed %b expected %b", e.tag, tick, e.t); end
        checks++;
        assert (busy === e.b) else begin errors++; $error("FAIL %s busy: observed %b expected %b", e.tag, busy, e.b); end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] dv, input logic os, input string tag,
                      input logic [3:0] et, input logic [3:0] eb);
        wr_en = 1'b1; wr_chan = ch; wr_div = dv; wr_oneshot = os;
        cyc(tag, et, eb);
        wr_en = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; wr_en = 1'b0; wr_en3 = 1'b0; wr_chan = '0; wr_div = '0; wr_oneshot = 1'b0;
        ch_en = '0; ch_en3 = '0;
`ifdef RATE_DIV_SYNC_EN
        sync_all = 1'b0;
`endif
        #2;
        checks++;
        assert (tick === 4'b0 && busy === 4'b0) else begin errors++; $error("FAIL rst_init: observed %b/%b expected 0000/0000", tick, busy); end
        ch_en = 4'b1111;
        cyc("in_reset", 4'b0000, 4'b0000);
        cyc("in_reset", 4'b0000, 4'b0000);
        resetn = 1'b1; ch_en = 4'b0001;
        for (int e = 1; e <= 30; e++) cyc("periodic_d9", (e % 10 == 0) ? 4'b0001 : 4'b0000, 4'b0001);
        for (int e = 1; e <= 4; e++) cyc("count_to_q5", 4'b0000, 4'b0001);
        wr(2'd0, 8'd2, 1'b0, "wr_mid_count", 4'b0000, 4'b0001);
        for (int e = 1; e <= 6; e++) cyc("after_wr_d2", (e % 3 == 0) ? 4'b0001 : 4'b0000, 4'b0001);
        ch_en = 4'b0000;
        cyc("disable", 4'b0000, 4'b0000);
        wr(2'd2, 8'd3, 1'b1, "wr_oneshot", 4'b0000, 4'b0000);
        ch_en = 4'b0100;
        for (int e = 1; e <= 8; e++) cyc("oneshot", (e == 4) ? 4'b0100 : 4'b0000, (e < 4) ? 4'b0100 : 4'b0000);
        ch_en = 4'b0000;
        cyc("oneshot_rearm", 4'b0000, 4'b0000);
        ch_en = 4'b0100;
        for (int e = 1; e <= 5; e++) cyc("oneshot_again", (e == 4) ? 4'b0100 : 4'b0000, (e < 4) ? 4'b0100 : 4'b0000);
        ch_en = 4'b0000;
        cyc("disable", 4'b0000, 4'b0000);
        wr(2'd1, 8'd0, 1'b0, "wr_d0", 4'b0000, 4'b0000);
        ch_en = 4'b0010;
        for (int e = 1; e <= 5; e++) cyc("d0_const", 4'b0010, 4'b0010);
        ch_en = 4'b0011;
        cyc("others_run", 4'b0010, 4'b0011);
        wr(2'd2, 8'd5, 1'b0, "wr_other", 4'b0010, 4'b0011);
        cyc("others_run", 4'b0011, 4'b0011);
        cyc("others_run", 4'b0010, 4'b0011);
        ch_en = 4'b0000;
        cyc("disable", 4'b0000, 4'b0000);
        ch_en3 = 3'b111;
        for (int e = 1; e <= 10; e++) begin
            if (e == 5) begin wr_en3 = 1'b1; wr_chan = 2'd3; wr_div = 8'd0; wr_oneshot = 1'b1; end
            cyc("bad_chan_main", 4'b0000, 4'b0000);
            wr_en3 = 1'b0;
            checks++;
            assert (tick3 === ((e == 10) ? 3'b111 : 3'b000)) else begin errors++; $error("FAIL bad_chan tick3 e=%0d: observed %b expected %b", e, tick3, (e == 10) ? 3'b111 : 3'b000); end
            checks++;
            assert (busy3 === 3'b111) else begin errors++; $error("FAIL bad_chan busy3 e=%0d: observed %b expected 111", e, busy3); end
        end
        ch_en3 = 3'b000;
        ch_en = 4'b0011;
        cyc("pre_reset", 4'b0010, 4'b0011);
        #3 resetn = 1'b0;
        #1;
        checks++;
        assert (tick === 4'b0000 && busy === 4'b0000) else begin errors++; $error("FAIL async_reset: observed %b/%b expected 0000/0000", tick, busy); end
        cyc("held_reset", 4'b0000, 4'b0000);
        resetn = 1'b1;
        for (int e = 1; e <= 10; e++) cyc("restart_d9", (e == 10) ? 4'b0011 : 4'b0000, 4'b0011);
`ifdef RATE_DIV_SYNC_EN
        ch_en = 4'b0000;
        cyc("disable", 4'b0000, 4'b0000);
        wr(2'd0, 8'd4, 1'b0, "wr_ch0", 4'b0000, 4'b0000);
        wr(2'd3, 8'd4, 1'b0, "wr_ch3", 4'b0000, 4'b0000);
        ch_en = 4'b0001;
        cyc("phase", 4'b0000, 4'b0001);
        cyc("phase", 4'b0000, 4'b0001);
        ch_en = 4'b1001;
        cyc("phase", 4'b0000, 4'b1001);
        sync_all = 1'b1;
        cyc("sync", 4'b0000, 4'b1001);
        sync_all = 1'b0;
        for (int e = 1; e <= 10; e++) cyc("synced", (e % 5 == 0) ? 4'b1001 : 4'b0000, 4'b1001);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
